// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer of the 2-stage cpu.
// The FSM encoding is exposed on the debug "state" output. Board displays
// decode those raw 2-bit values, so the encoding must stay fixed.
package pc_sequencer_pkg;

    // Symbolic view of the sequencer states, handy for displays and benches.
    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    // Raw constants used by the FSM itself. They match seq_state_t one-to-one.
    localparam logic [1:0] ST_HALT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Instruction the EX register loads on flush_ex/stall (addi x0,x0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // True in the states that issue a fetch on the next edge.
    function automatic logic seq_advances(input logic [1:0] st);
        return (st == ST_RUN) || (st == ST_STEP);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the board/EX stage (master) and the fetch
// sequencer (slave). The master drives the run controls and the redirect
// request. The slave returns the fetch address, flush/stall and valid bits.
interface pc_sequencer_if #(
    parameter int PC_W = 12
);
    // Board controls and EX-stage redirect request.
    logic            run_en;
    logic            halt_req;
    logic            step_req;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;

    // Sequencer results.
    logic [PC_W-1:0] pc_f;
    logic            flush_ex;
    logic            stall;
    logic            ex_valid;
    logic            wb_valid;
    logic [1:0]      state;
    logic [31:0]     retired_cnt;

    modport master (
        output run_en,
        output halt_req,
        output step_req,
        output redirect_valid,
        output redirect_pc,
        input  pc_f,
        input  flush_ex,
        input  stall,
        input  ex_valid,
        input  wb_valid,
        input  state,
        input  retired_cnt
    );

    modport slave (
        input  run_en,
        input  halt_req,
        input  step_req,
        input  redirect_valid,
        input  redirect_pc,
        output pc_f,
        output flush_ex,
        output stall,
        output ex_valid,
        output wb_valid,
        output state,
        output retired_cnt
    );

endinterface

// File: rtl/pc_sequencer_rise_detect.sv
// One-cycle pulse on each rising edge of a level input. The step key uses
// this block. The delay register samples every cycle, whatever the state of
// the consumer. A level held high therefore yields exactly one pulse.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic d_q;

    // Remember the previous level of d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and instruction-valid tracking for the fetch -> EX -> WB
// pipeline. A small FSM sequences fetch. It can free-run or single-step, and
// it always drains the pipe before it halts. A taken branch/jump from EX
// redirects pc_f. The same edge squashes the wrong-path fetch, which leaves
// one bubble. The ex/wb valid bits let the datapath suppress side effects of
// bubbles.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            ex_valid_q, ex_valid_d;
    logic            wb_valid_q, wb_valid_d;
    logic [31:0]     retired_q, retired_d;

    logic            step_edge;
    logic            go;
    logic            adv;
    logic            redir;

    // Step key edge detector. It samples in every state, so an edge that
    // arrives outside HALT is consumed and lost, not queued.
    rise_detect u_step_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.step_req),
        .pulse (step_edge)
    );

    // Fetch control terms. A redirect is honoured only for a real EX
    // instruction on an issuing cycle. A stale target on a bubble is ignored.
    always_comb begin
        go    = bus.run_en & ~bus.halt_req;
        adv   = seq_advances(state_q);
        redir = bus.redirect_valid & ex_valid_q & adv;
    end

    // Sequencer FSM next state. go beats a step edge in HALT. STEP issues one
    // fetch, then DRAIN gives that fetch a cycle to move from EX into WB.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (go) begin
                    state_d = ST_RUN;
                end else if (step_edge) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (!go) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_STEP:  state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_HALT;
            default:  state_d = ST_HALT;
        endcase
    end

    // PC, pipeline valid bits and retire counter. A redirect takes priority
    // over the sequential increment and turns the fetched slot into a bubble.
    always_comb begin
        pc_d = pc_q;
        if (redir) begin
            pc_d = bus.redirect_pc;
        end else if (adv) begin
            pc_d = pc_q + PC_ONE;
        end
        ex_valid_d = adv & ~redir;
        wb_valid_d = ex_valid_q;
        retired_d  = retired_q + {31'd0, wb_valid_q};
    end

    // State registers. Asserting reset drops all in-flight instructions at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HALT;
            pc_q       <= RESET_PC;
            ex_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
            retired_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ex_valid_q <= ex_valid_d;
            wb_valid_q <= wb_valid_d;
            retired_q  <= retired_d;
        end
    end

    // During reset state_q sits in HALT, so stall and flush_ex read 1.
    assign bus.stall       = ~adv;
    assign bus.flush_ex    = ~adv | redir;
    assign bus.pc_f        = pc_q;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.state       = state_q;
    assign bus.retired_cnt = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Inputs change just after the falling
// edge, and outputs are checked there, half a cycle away from the active edge.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int PC_W = 12;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    pc_sequencer_if #(.PC_W(PC_W)) bus ();

    pc_sequencer #(.PC_W(PC_W), .RESET_PC(12'h000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pipe(input string tag, input logic [1:0] st, input logic [11:0] pc,
                            input logic ex, input logic wb, input logic [31:0] ret);
        chk({tag, ".state"},   {30'd0, bus.state}, {30'd0, st});
        chk({tag, ".pc_f"},    {20'd0, bus.pc_f},  {20'd0, pc});
        chk({tag, ".ex_valid"}, {31'd0, bus.ex_valid}, {31'd0, ex});
        chk({tag, ".wb_valid"}, {31'd0, bus.wb_valid}, {31'd0, wb});
        chk({tag, ".retired"}, bus.retired_cnt, ret);
        $display("step %-10s state=%0d pc_f=%03h ex=%0b wb=%0b retired=%0d",
                 tag, bus.state, bus.pc_f, bus.ex_valid, bus.wb_valid, bus.retired_cnt);
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.run_en         = 1'b1;
        bus.halt_req       = 1'b0;
        bus.step_req       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 12'h000;

        // 1. Reset, then free-run from address 0.
        cyc();
        chk_pipe("reset", 2'd0, 12'h000, 1'b0, 1'b0, 32'd0);
        chk("reset.stall", {31'd0, bus.stall}, 32'd1);
        chk("reset.flush", {31'd0, bus.flush_ex}, 32'd1);
        rst_n = 1'b1;
        cyc(); chk_pipe("run0", 2'd1, 12'h000, 1'b0, 1'b0, 32'd0);
        chk("run0.stall", {31'd0, bus.stall}, 32'd0);
        cyc(); chk_pipe("run1", 2'd1, 12'h001, 1'b1, 1'b0, 32'd0);
        cyc(); chk_pipe("run2", 2'd1, 12'h002, 1'b1, 1'b1, 32'd0);
        cyc(); chk_pipe("run3", 2'd1, 12'h003, 1'b1, 1'b1, 32'd1);
        cyc(); cyc(); chk_pipe("run5", 2'd1, 12'h005, 1'b1, 1'b1, 32'd3);

        // 2. Taken redirect at pc_f=5 -> 0x020 with a single bubble.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 12'h020;
        #1 chk("redir.flush", {31'd0, bus.flush_ex}, 32'd1);
        cyc(); bus.redirect_valid = 1'b0;
        chk_pipe("redir1", 2'd1, 12'h020, 1'b0, 1'b1, 32'd4);
        cyc(); chk_pipe("redir2", 2'd1, 12'h021, 1'b1, 1'b0, 32'd5);
        cyc(); chk_pipe("redir3", 2'd1, 12'h022, 1'b1, 1'b1, 32'd5);

        // 4. Stop and redirect on the same cycle, then resume at the target.
        bus.run_en         = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 12'h100;
        #1 chk("stopredir.flush", {31'd0, bus.flush_ex}, 32'd1);
        cyc(); bus.redirect_valid = 1'b0;
        chk_pipe("stopredir1", 2'd3, 12'h100, 1'b0, 1'b1, 32'd6);
        cyc(); chk_pipe("stopredir2", 2'd0, 12'h100, 1'b0, 1'b0, 32'd7);
        cyc(); chk_pipe("held", 2'd0, 12'h100, 1'b0, 1'b0, 32'd7);
        bus.run_en = 1'b1;
        cyc(); chk_pipe("resume0", 2'd1, 12'h100, 1'b0, 1'b0, 32'd7);
        cyc(); chk_pipe("resume1", 2'd1, 12'h101, 1'b1, 1'b0, 32'd7);
        bus.run_en = 1'b0;
        cyc(); chk_pipe("stop1", 2'd3, 12'h102, 1'b1, 1'b1, 32'd7);
        cyc(); chk_pipe("stop2", 2'd0, 12'h102, 1'b0, 1'b1, 32'd8);
        cyc(); chk_pipe("stop3", 2'd0, 12'h102, 1'b0, 1'b0, 32'd9);

        // 3. Three single steps while halted.
        for (int i = 0; i < 3; i++) begin
            bus.step_req = 1'b1;
            cyc(); chk("step.STEP", {30'd0, bus.state}, 32'd2);
            bus.step_req = 1'b0;
            cyc(); chk("step.DRAIN", {30'd0, bus.state}, 32'd3);
            cyc(); chk("step.HALT", {30'd0, bus.state}, 32'd0);
            cyc();
        end
        chk_pipe("stepped", 2'd0, 12'h105, 1'b0, 1'b0, 32'd12);

        // 5. A redirect on a bubble is ignored. Then wrap pc_f from 0xFFF to 0x000.
        bus.run_en = 1'b1;
        cyc(); chk_pipe("rerun", 2'd1, 12'h105, 1'b0, 1'b0, 32'd12);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 12'h055;
        #1 chk("bubble.flush", {31'd0, bus.flush_ex}, 32'd0);
        cyc(); chk("bubble.pc_f", {20'd0, bus.pc_f}, 32'h106);
        bus.redirect_pc = 12'hFFF;
        cyc(); bus.redirect_valid = 1'b0;
        chk("wrap.pre", {20'd0, bus.pc_f}, 32'hFFF);
        cyc(); chk("wrap.post", {20'd0, bus.pc_f}, 32'h000);
        cyc(); chk("wrap.next", {20'd0, bus.pc_f}, 32'h001);

        // 6. Reset asserted mid-run between edges clears state right away.
        #2 rst_n = 1'b0;
        #1 chk_pipe("midreset", 2'd0, 12'h000, 1'b0, 1'b0, 32'd0);
        chk("midreset.stall", {31'd0, bus.stall}, 32'd1);
        chk("midreset.flush", {31'd0, bus.flush_ex}, 32'd1);

        // Restart with go and a step edge together: RUN wins. Then halt_req drains.
        cyc();
        bus.step_req = 1'b1;
        rst_n = 1'b1;
        cyc(); chk("gostep.state", {30'd0, bus.state}, 32'd1);
        bus.step_req = 1'b0;
        bus.halt_req = 1'b1;
        cyc(); chk("halt.state", {30'd0, bus.state}, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
